// File: rtl/sram_bank_arbiter_if.sv
// Downstream SRAM bank port: one request channel (valid/ready) and an
// in-order response channel (valid only, no backpressure).
//   master : driven by the arbiter (issues requests, consumes responses)
//   slave  : driven by the bank/memory side
//   mem_req_valid/ready/we/bank/addr/wdata - request handshake and payload
//   mem_resp_valid/mem_resp_rdata          - in-order response
interface sram_bank_arbiter_if #(
  parameter int unsigned BW         = 2,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [BW-1:0]         mem_req_bank;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_bank, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_bank, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter from NUM_REQ requesters onto one downstream SRAM bank
// port, with a tag FIFO routing in-order responses back to their owner.
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   rq_valid/ready  - per-requester handshake (rq_ready one-hot or zero)
//   rq_we/bank/addr/wdata - packed per-requester payload, slice i = requester i
//   rs_valid        - one-hot response strobe to the owning requester
//   rs_rdata        - response data broadcast to all requesters
//   mem             - downstream bank port (sram_bank_arbiter_if.master)
//   err_unexp_resp  - sticky: response arrived with no tag outstanding
//   perf_stall_cnt  - saturating stall-cycle counter, present only when
//                     SRAM_ARB_PERF_CNT_EN is defined
module sram_bank_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_OUT    = 4,
  localparam int unsigned BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               rq_valid,
  output logic [NUM_REQ-1:0]               rq_ready,
  input  logic [NUM_REQ-1:0]               rq_we,
  input  logic [NUM_REQ*BW-1:0]            rq_bank,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rq_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    rq_wdata,
  output logic [NUM_REQ-1:0]               rs_valid,
  output logic [DATA_WIDTH-1:0]            rs_rdata,
  sram_bank_arbiter_if.master              mem,
  output logic                             err_unexp_resp
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_stall_cnt
`endif
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUT + 1);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] hold_sel;
  logic [IDW-1:0] rr_sel;
  logic           rr_found;
  int unsigned    rr_idx;
  logic [IDW-1:0] cur_sel;

  logic [IDW-1:0] tag_mem [MAX_OUT];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic           req_pending;
  logic           fifo_full;
  logic           pop;
  logic           issue;
  logic           hs;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    rr_sel   = last_grant;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (32'(last_grant) + k) % NUM_REQ;
      if (!rr_found && rq_valid[IDW'(rr_idx)]) begin
        rr_found = 1'b1;
        rr_sel   = IDW'(rr_idx);
      end
    end
  end

  // In HOLD the latched grant is presented without re-arbitration.
  assign cur_sel     = (state == ST_HOLD) ? hold_sel : rr_sel;
  assign req_pending = (state == ST_HOLD) || rr_found;
  assign fifo_full   = (count == CW'(MAX_OUT));
  // A response with nothing outstanding is an error, never a pop.
  assign pop         = !rst && mem.mem_resp_valid && (count != '0);
  // A same-cycle pop frees a slot, so a full FIFO may still issue.
  assign issue       = !rst && req_pending && (!fifo_full || pop);
  assign hs          = issue && mem.mem_req_ready;

  // Zero-latency request pass-through and response routing.
  always_comb begin
    mem.mem_req_valid = issue;
    mem.mem_req_we    = rq_we[cur_sel];
    mem.mem_req_bank  = rq_bank[32'(cur_sel)*BW +: BW];
    mem.mem_req_addr  = rq_addr[32'(cur_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    mem.mem_req_wdata = rq_wdata[32'(cur_sel)*DATA_WIDTH +: DATA_WIDTH];
    rq_ready          = '0;
    if (hs) begin
      rq_ready[cur_sel] = 1'b1;
    end
    rs_valid          = '0;
    if (pop) begin
      rs_valid[tag_mem[rd_ptr]] = 1'b1;
    end
    rs_rdata          = mem.mem_resp_rdata;
  end

  // Grant FSM, round-robin pointer, FIFO bookkeeping and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_ARB;
      hold_sel       <= '0;
      last_grant     <= IDW'(NUM_REQ - 1);
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_unexp_resp <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          if (issue && !mem.mem_req_ready) begin
            state    <= ST_HOLD;
            hold_sel <= rr_sel;
          end
        end
        ST_HOLD: begin
          if (hs) begin
            state <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase

      if (hs) begin
        last_grant <= cur_sel;
        wr_ptr     <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (hs && !pop) begin
        count <= count + CW'(1);
      end else if (!hs && pop) begin
        count <= count - CW'(1);
      end

      if (mem.mem_resp_valid && (count == '0)) begin
        err_unexp_resp <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (hs) begin
      tag_mem[wr_ptr] <= cur_sel;
    end
  end

`ifdef SRAM_ARB_PERF_CNT_EN
  // Cycles with a request waiting but no handshake, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if ((|rq_valid) && !hs && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Randomized and directed bench for sram_bank_arbiter against a queue-based
// reference model. Define SRAM_ARB_PERF_CNT_EN to also check perf_stall_cnt.
module tb_sram_bank_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned NB = 4;
  localparam int unsigned BW = 2;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rq_valid;
  logic [NR-1:0]     rq_ready;
  logic [NR-1:0]     rq_we;
  logic [NR*BW-1:0]  rq_bank;
  logic [NR*AW-1:0]  rq_addr;
  logic [NR*DW-1:0]  rq_wdata;
  logic [NR-1:0]     rs_valid;
  logic [DW-1:0]     rs_rdata;
  logic              err_unexp_resp;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0]       perf_stall_cnt;
`endif

  sram_bank_arbiter_if #(.BW(BW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  sram_bank_arbiter #(
    .NUM_REQ(NR), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUT(MO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rq_valid(rq_valid),
    .rq_ready(rq_ready),
    .rq_we(rq_we),
    .rq_bank(rq_bank),
    .rq_addr(rq_addr),
    .rq_wdata(rq_wdata),
    .rs_valid(rs_valid),
    .rs_rdata(rs_rdata),
    .mem(mem_if),
    .err_unexp_resp(err_unexp_resp)
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          q[$];
  int          last_m = NR - 1;
  int          held_m = -1;
  bit          err_m  = 1'b0;
  logic [31:0] perf_m = '0;
  bit          hs_m;
  int          sel_m;

  // Observed values of the most recent cycle
  logic [NR-1:0] obs_rdy, obs_rs;
  logic          obs_mv, obs_err;
  logic [AW-1:0] obs_addr;
  logic [31:0]   obs_perf;

  bit keep_all  = 1'b0;
  bit auto_resp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int i, input bit we);
    rq_valid[i]            = 1'b1;
    rq_we[i]               = we;
    rq_bank[i*BW +: BW]    = BW'($urandom);
    rq_addr[i*AW +: AW]    = AW'($urandom);
    rq_wdata[i*DW +: DW]   = $urandom;
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic model_step();
    int            sel;
    bit            issue, pop, hs;
    logic [NR-1:0] exp_rdy, exp_rs;
    obs_rdy  = rq_ready;
    obs_mv   = mem_if.mem_req_valid;
    obs_rs   = rs_valid;
    obs_err  = err_unexp_resp;
    obs_addr = mem_if.mem_req_addr;
`ifdef SRAM_ARB_PERF_CNT_EN
    obs_perf = perf_stall_cnt;
`else
    obs_perf = '0;
`endif
    hs_m = 1'b0;
    if (rst) begin
      check("rst_rq_ready", 64'(rq_ready), 64'(0));
      check("rst_rs_valid", 64'(rs_valid), 64'(0));
      check("rst_mem_valid", 64'(mem_if.mem_req_valid), 64'(0));
      q.delete();
      last_m = NR - 1;
      held_m = -1;
      err_m  = 1'b0;
      perf_m = '0;
      return;
    end

    check("err_flag", 64'(err_unexp_resp), 64'(err_m));
`ifdef SRAM_ARB_PERF_CNT_EN
    check("perf_cnt", 64'(perf_stall_cnt), 64'(perf_m));
`endif

    pop    = mem_if.mem_resp_valid && (q.size() > 0);
    exp_rs = '0;
    if (pop) exp_rs[q[0]] = 1'b1;
    check("rs_valid", 64'(rs_valid), 64'(exp_rs));
    if (pop) check("rs_rdata", 64'(rs_rdata), 64'(mem_if.mem_resp_rdata));

    sel = held_m;
    if (sel < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (last_m + k) % NR;
        if (sel < 0 && rq_valid[idx]) sel = idx;
      end
    end
    issue = (sel >= 0) && ((q.size() < MO) || pop);
    check("mem_req_valid", 64'(mem_if.mem_req_valid), 64'(issue));
    if (issue) begin
      check("mem_req_we", 64'(mem_if.mem_req_we), 64'(rq_we[sel]));
      check("mem_req_bank", 64'(mem_if.mem_req_bank), 64'(rq_bank[sel*BW +: BW]));
      check("mem_req_addr", 64'(mem_if.mem_req_addr), 64'(rq_addr[sel*AW +: AW]));
      check("mem_req_wdata", 64'(mem_if.mem_req_wdata), 64'(rq_wdata[sel*DW +: DW]));
    end
    hs      = issue && mem_if.mem_req_ready;
    exp_rdy = '0;
    if (hs) exp_rdy[sel] = 1'b1;
    check("rq_ready", 64'(rq_ready), 64'(exp_rdy));

    if (mem_if.mem_resp_valid && q.size() == 0) err_m = 1'b1;
    if (pop) void'(q.pop_front());
    if (hs) begin
      q.push_back(sel);
      last_m = sel;
      held_m = -1;
    end else if (issue) begin
      held_m = sel;
    end
    if ((|rq_valid) && !hs && perf_m != 32'hFFFF_FFFF) perf_m = perf_m + 32'd1;
    hs_m  = hs;
    sel_m = sel;
  endtask

  // Called at posedge+1; samples at the following negedge, returns at posedge+1.
  task automatic run_cycle();
    #4;
    model_step();
    @(posedge clk);
    #1;
    if (hs_m) begin
      rq_valid[sel_m] = 1'b0;
      if (keep_all) raise(sel_m, 1'b0);
    end
    if (auto_resp) begin
      mem_if.mem_resp_valid = (q.size() > 0);
      mem_if.mem_resp_rdata = $urandom;
    end
  endtask

  task automatic reset_dut();
    rst                   = 1'b1;
    rq_valid              = '0;
    keep_all              = 1'b0;
    auto_resp             = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_req_ready  = 1'b0;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] addr2;
    rst                   = 1'b1;
    rq_valid              = '0;
    rq_we                 = '0;
    rq_bank               = '0;
    rq_addr               = '0;
    rq_wdata              = '0;
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_rdata = '0;
    @(posedge clk);
    #1;

    // Round robin with all requesters busy and immediate responses
    reset_dut();
    check("reset_err", 64'(err_unexp_resp), 64'(0));
    keep_all = 1'b1;
    auto_resp = 1'b1;
    mem_if.mem_req_ready = 1'b1;
    for (int i = 0; i < NR; i++) raise(i, 1'b0);
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      check("rr_grant", 64'(obs_rdy), 64'(1 << (c % 4)));
    end

    // Backpressure holds the grant on requester 2
    reset_dut();
    auto_resp = 1'b1;
    mem_if.mem_req_ready = 1'b1;
    raise(0, 1'b0);
    run_cycle();
    raise(1, 1'b0);
    run_cycle();
    raise(2, 1'b1);
    raise(3, 1'b0);
    addr2 = rq_addr[2*AW +: AW];
    mem_if.mem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      check("hold_valid", 64'(obs_mv), 64'(1));
      check("hold_addr", 64'(obs_addr), 64'(addr2));
      check("hold_rdy", 64'(obs_rdy), 64'(0));
      if (c == 0) raise(1, 1'b0);
    end
    mem_if.mem_req_ready = 1'b1;
    run_cycle();
    check("hold_accept", 64'(obs_rdy), 64'(4'b0100));
    run_cycle();
    check("hold_next3", 64'(obs_rdy), 64'(4'b1000));
    run_cycle();
    check("hold_then1", 64'(obs_rdy), 64'(4'b0010));

    // Full tag FIFO blocks; a response frees it in the same cycle
    reset_dut();
    keep_all = 1'b1;
    mem_if.mem_req_ready = 1'b1;
    for (int i = 0; i < NR; i++) raise(i, 1'b0);
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      check("fill_issue", 64'(obs_mv), 64'(1));
    end
    run_cycle();
    check("full_block", 64'(obs_mv), 64'(0));
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_rdata = 32'h1234_5678;
    run_cycle();
    check("full_pop_issue", 64'(obs_mv), 64'(1));
    check("full_pop_rs", 64'(obs_rs), 64'(4'b0001));
    check("full_pop_grant", 64'(obs_rdy), 64'(4'b0001));
    mem_if.mem_resp_valid = 1'b0;

    // Responses routed back to requesters 1 and 3 in order
    reset_dut();
    mem_if.mem_req_ready = 1'b1;
    raise(1, 1'b0);
    raise(3, 1'b0);
    run_cycle();
    check("rt_grant1", 64'(obs_rdy), 64'(4'b0010));
    run_cycle();
    check("rt_grant3", 64'(obs_rdy), 64'(4'b1000));
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_rdata = 32'hAAAA_0001;
    run_cycle();
    check("rt_rs1", 64'(obs_rs), 64'(4'b0010));
    mem_if.mem_resp_rdata = 32'hBBBB_0003;
    run_cycle();
    check("rt_rs3", 64'(obs_rs), 64'(4'b1000));
    mem_if.mem_resp_valid = 1'b0;

    // Unexpected response sets a sticky error
    reset_dut();
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_rdata = 32'hDEAD_BEEF;
    run_cycle();
    check("unexp_rs", 64'(obs_rs), 64'(0));
    mem_if.mem_resp_valid = 1'b0;
    run_cycle();
    check("unexp_err", 64'(obs_err), 64'(1));
    repeat (3) run_cycle();
    check("unexp_sticky", 64'(obs_err), 64'(1));
    reset_dut();
    run_cycle();
    check("err_cleared", 64'(obs_err), 64'(0));

    // Reset discards outstanding tags
    reset_dut();
    mem_if.mem_req_ready = 1'b1;
    raise(0, 1'b0);
    raise(1, 1'b1);
    run_cycle();
    run_cycle();
    reset_dut();
    mem_if.mem_resp_valid = 1'b1;
    run_cycle();
    check("post_rst_rs", 64'(obs_rs), 64'(0));
    mem_if.mem_resp_valid = 1'b0;
    run_cycle();
    check("post_rst_err", 64'(obs_err), 64'(1));

`ifdef SRAM_ARB_PERF_CNT_EN
    reset_dut();
    raise(2, 1'b0);
    repeat (5) run_cycle();
    run_cycle();
    check("perf_five", 64'(obs_perf), 64'(5));
`endif

    // Randomized traffic with backpressure, random responses and resets
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!rq_valid[i] && $urandom_range(0, 2) == 0) raise(i, 1'($urandom_range(0, 1)));
      end
      mem_if.mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_if.mem_resp_valid = (q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                             : ($urandom_range(0, 40) == 0);
      mem_if.mem_resp_rdata = $urandom;
      rst = ($urandom_range(0, 499) == 0);
      run_cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_bank_arbiter.md
SRAM_BANK_ARBITER -- requirements
Module: sram_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-002 SHALL have parameter NUM_BANKS, default 4, the number of banks in the downstream bank port.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, the word address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, the data width.
REQ-005 SHALL have parameter MAX_OUT, default 4, the maximum number of outstanding downstream requests (power of 2).
REQ-006 SHALL have port clk, input, 1, the single clock; every flop is rising-edge.
REQ-007 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-008 SHALL have port rq_valid, input, NUM_REQ, a per-requester request valid.
REQ-009 SHALL have port rq_ready, output, NUM_REQ, a per-requester accept; it is one-hot or zero.
REQ-010 SHALL have port rq_we, input, NUM_REQ, a per-requester write enable.
REQ-011 SHALL have port rq_bank, input, NUM_REQ*BW, the packed bank select, where BW=$clog2(NUM_BANKS); requester i occupies slice i.
REQ-012 SHALL have port rq_addr, input, NUM_REQ*ADDR_WIDTH, the packed word address.
REQ-013 SHALL have port rq_wdata, input, NUM_REQ*DATA_WIDTH, the packed write data.
REQ-014 SHALL have port rs_valid, output, NUM_REQ, a one-hot response strobe to the owning requester.
REQ-015 SHALL have port rs_rdata, output, DATA_WIDTH, the response data broadcast to all requesters.
REQ-016 SHALL have ports mem_req_valid/ready/we/bank/addr/wdata, out/in/out/out/out/out, 1/1/1/BW/ADDR_WIDTH/DATA_WIDTH, the downstream bank request.
REQ-017 SHALL have ports mem_resp_valid/mem_resp_rdata, input, 1/DATA_WIDTH, the downstream in-order response.
REQ-018 SHALL have port err_unexp_resp, output, 1, a sticky flag for a response that arrives with no tag outstanding.

Function
REQ-019 SHALL perform round-robin arbitration: the search starts at (last_grant+1) mod NUM_REQ, and the first rq_valid found is selected.
REQ-020 SHALL use a two-state FSM, ARB and HOLD, with ARB as the reset state.
REQ-021 SHALL behave in ARB as follows: when any rq_valid is set and the tag FIFO is not full, drive mem_req_valid=1 with the selected requester's fields.
REQ-022 SHALL complete a handshake when mem_req_valid&&mem_req_ready in the same cycle; on that cycle rq_ready[sel]=1, the tag is pushed, last_grant<=sel, and the FSM stays in ARB.
REQ-023 SHALL, when in ARB with mem_req_valid=1 and mem_req_ready=0, latch sel and go to HOLD.
REQ-024 SHALL keep the latched grant in HOLD, with no re-arbitration and mem_req_* stable, until mem_req_ready, then return to ARB.
REQ-025 SHALL let requesters rely on the rule that rq_valid, once raised, stays asserted with stable fields until rq_ready.
REQ-026 SHALL have combinational paths from the request inputs and mem_req_ready to the outputs, so issue latency is 0 cycles; requester-to-downstream throughput is 1 request per cycle.
REQ-027 SHALL keep a tag FIFO of MAX_OUT entries, each holding the $clog2(NUM_REQ) requester ID; every accepted request (read or write) expects exactly one mem_resp_valid.
REQ-028 SHALL, on mem_resp_valid, pop the FIFO head, set rs_valid[head]=1 in the same cycle, and drive rs_rdata=mem_resp_rdata.
REQ-029 SHALL treat the FIFO as full when count==MAX_OUT; when full, mem_req_valid=0 unless a pop happens in the same cycle, in which case issue is allowed.
REQ-030 SHALL, on a simultaneous push and pop, leave count unchanged; the FIFO pointers wrap modulo MAX_OUT.
REQ-031 SHALL, on mem_resp_valid with count==0, set err_unexp_resp=1 (sticky until reset), drive no rs_valid, and leave count unchanged.
REQ-032 SHALL not produce a response sooner than in the same cycle as the downstream pass-through; the FIFO bypass (push and pop of the same tag in one cycle) returns the correct ID.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, set FSM=ARB, last_grant=NUM_REQ-1 (so requester 0 wins first), FIFO count and pointers=0, and err_unexp_resp=0.
REQ-034 SHALL hold rq_ready=0, rs_valid=0 and mem_req_valid=0 while rst=1.
REQ-035 SHALL, on a reset mid-operation, discard all outstanding tags; responses arriving after the reset set err_unexp_resp.

Configuration
REQ-036 SHALL, when macro SRAM_ARB_PERF_CNT_EN is defined, add output perf_stall_cnt[31:0], which counts cycles with rq_valid!=0 and no handshake and saturates at 0xFFFFFFFF.
REQ-037 SHALL, when SRAM_ARB_PERF_CNT_EN is defined, clear perf_stall_cnt on rst.
REQ-038 SHALL, without SRAM_ARB_PERF_CNT_EN, have neither that port nor that logic.

Verification
REQ-039 SHALL cover: after reset, rq_valid=4'b1111 with mem_req_ready=1 and immediate responses -> grants go 0,1,2,3,0, one per cycle.
REQ-040 SHALL cover: mem_req_ready=0 for 3 cycles while req 2 is selected and req 1 then rises -> grant stays 2 with stable fields; on ready, 2 is accepted, then 3 (not 1) if valid, else 1.
REQ-041 SHALL cover: with MAX_OUT=4, issue 4 reads with no response -> 5th held with mem_req_valid=0; one response arrives -> 5th issues in that same cycle.
REQ-042 SHALL cover: reqs 1 and 3 read with responses 0xAAAA_0001 and 0xBBBB_0003 in order -> rs_valid=4'b0010 with 0xAAAA_0001, then 4'b1000 with 0xBBBB_0003.
REQ-043 SHALL cover: mem_resp_valid with nothing outstanding -> err_unexp_resp=1, rs_valid=0, and it remains 1 until rst.
REQ-044 SHALL cover: rst asserted with 2 tags outstanding -> count=0, and a later response sets err_unexp_resp; with SRAM_ARB_PERF_CNT_EN, 5 stalled cycles -> perf_stall_cnt=5.
